// File: rtl/jt49_cen_gen.sv
// jt49_cen_gen: clock-enable generator for the PSG datapath.
// A base enable is taken from cen, optionally thinned by a fractional
// num/den accumulator so non-integer master-clock ratios can be matched.
// A free-running divider counter advanced by the base enable produces
// NTAP power-of-two tap enables with programmable exponents.
//
// State summary (no FSM):
//   acc : fractional accumulator, FW bits
//   cnt : divider counter, CW bits, wraps freely
//   cen_base / cen_tap : registered enables, one cycle after cen
module jt49_cen_gen #(
  parameter int NTAP = 2,
  parameter int CW   = 10,
  parameter int FW   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cen,
  input  logic              frac_en,
  input  logic [FW-1:0]     frac_num,
  input  logic [FW-1:0]     frac_den,
  input  logic              sel,
  input  logic [NTAP*4-1:0] tap_exp,
  input  logic              resync,
  output logic              cen_base,
  output logic [NTAP-1:0]   cen_tap,
  output logic [CW-1:0]     cnt
);

  // Fractional accumulator and its one-bit-wider running sum.
  logic [FW-1:0] acc;
  logic [FW-1:0] acc_nxt;
  logic [FW:0]   sum;

  // Decoded fractional conditions.
  logic den_zero;
  logic clamp;
  logic reach;

  // Combinational base enable, before registering.
  logic b;

  // Per-tap effective exponent, low-bit mask and toggle decision.
  logic [31:0]   e_raw   [NTAP];
  logic [31:0]   e_eff   [NTAP];
  logic [CW-1:0] tap_mask[NTAP];
  logic [NTAP-1:0] toggle;

  // The sum is kept FW+1 wide so the threshold compare never overflows.
  assign sum = {1'b0, acc} + {1'b0, frac_num};

  // Base enable: plain cen, or cen thinned by the accumulator threshold.
  always_comb begin
    den_zero = (frac_den == '0);
    clamp    = (frac_num >= frac_den);
    reach    = (sum >= {1'b0, frac_den});
    b        = cen;
    if (frac_en) begin
      if (den_zero) begin
        // A zero denominator would mean an infinite rate; keep quiet instead.
        b = 1'b0;
      end else if (clamp) begin
        // Ratio of one or more: every incoming cen passes.
        b = cen;
      end else begin
        b = cen & reach;
      end
    end
  end

  // Next accumulator value; only advances on an incoming cen in frac mode.
  always_comb begin
    acc_nxt = acc;
    if (cen && frac_en) begin
      if (!den_zero && clamp) begin
        // Clamped ratio: the remainder has no meaning, keep it where it is.
        acc_nxt = acc;
      end else if (b) begin
        // sum >= den and sum < 2*den here, so the difference fits FW bits.
        acc_nxt = FW'(sum - {1'b0, frac_den});
      end else begin
        acc_nxt = sum[FW-1:0];
      end
    end
  end

  // Effective exponent per tap: programmed value, plus one when sel is low,
  // saturated at the counter width.
  always_comb begin
    for (int i = 0; i < NTAP; i++) begin
      e_raw[i] = {28'd0, tap_exp[4*i +: 4]} + {31'd0, ~sel};
      if (e_raw[i] > 32'(CW)) begin
        e_eff[i] = 32'(CW);
      end else begin
        e_eff[i] = e_raw[i];
      end
    end
  end

  // Low-bit mask per tap: bits [e-1:0] set, empty for e = 0.
  always_comb begin
    for (int i = 0; i < NTAP; i++) begin
      tap_mask[i] = '0;
      for (int j = 0; j < CW; j++) begin
        if (32'(j) < e_eff[i]) begin
          tap_mask[i][j] = 1'b1;
        end
      end
    end
  end

  // A tap fires when the masked low bits of the pre-increment count are zero.
  // An empty mask (e = 0) makes the tap fire on every base enable.
  always_comb begin
    toggle = '0;
    for (int i = 0; i < NTAP; i++) begin
      toggle[i] = ((cnt & tap_mask[i]) == '0);
    end
  end

  // Accumulator register; resync clears it ahead of any update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (resync) begin
      acc <= '0;
    end else begin
      acc <= acc_nxt;
    end
  end

  // Divider counter; advances once per base enable and wraps with no stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (resync) begin
      cnt <= '0;
    end else if (b) begin
      cnt <= cnt + CW'(1);
    end
  end

  // Output flops: one cycle latency from cen; resync forces them low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cen_base <= 1'b0;
      cen_tap  <= '0;
    end else if (resync) begin
      cen_base <= 1'b0;
      cen_tap  <= '0;
    end else begin
      cen_base <= b;
      cen_tap  <= b ? toggle : '0;
    end
  end

endmodule
